// File: rtl/alu_muldiv.sv
// RV32I ALU plus M-extension iterative mul/div; ALU ops finish in 1 cycle, mul/div in XLEN+1.
// ready_o drops while busy, killed, or while a finished result is held waiting for ready_i.
module alu_muldiv #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic [4:0]      ctrl_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    hi, lo, opb;
  logic [2:0]         op;
  logic               res_neg, div0;

  logic               accept, is_md, last, a_signed, b_signed, a_neg, b_neg, neg_nxt;
  logic [XLEN-1:0]    alu_res, a_mag, b_mag, hi_nxt, lo_nxt, quo, rem, fin_res;
  logic [XLEN:0]      sum, rem_sh;
  logic [XLEN+1:0]    diff;
  logic [2*XLEN-1:0]  prod;
  logic [SHAMT_W-1:0] shamt;

  assign shamt   = in2_i[SHAMT_W-1:0];
  assign ready_o = !kill_i && (state == IDLE || (state == DONE && ready_i));
  assign accept  = valid_i && ready_o;
  assign valid_o = (state == DONE);
  assign is_md   = (ctrl_i >= 5'd10) && (ctrl_i <= 5'd17);
  assign last    = (cnt == SHAMT_W'(XLEN-1));

  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      5'd0:    alu_res = in1_i + in2_i;
      5'd1:    alu_res = in1_i & in2_i;
      5'd2:    alu_res = in1_i | in2_i;
      5'd3:    alu_res = in1_i ^ in2_i;
      5'd4:    alu_res = in1_i << shamt;
      5'd5:    alu_res = in1_i >> shamt;
      5'd6:    alu_res = XLEN'($signed(in1_i) >>> shamt);
      5'd7:    alu_res = in1_i - in2_i;
      5'd8:    alu_res = {{(XLEN-1){1'b0}}, (in1_i < in2_i)};
      5'd9:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in1_i) < $signed(in2_i))};
      default: alu_res = '0;
    endcase
  end

  // Operands become magnitudes; the sign of the final result is remembered in res_neg.
  always_comb begin
    a_signed = (ctrl_i == 5'd10) || (ctrl_i == 5'd11) || (ctrl_i == 5'd12) ||
               (ctrl_i == 5'd14) || (ctrl_i == 5'd16);
    b_signed = (ctrl_i == 5'd10) || (ctrl_i == 5'd11) || (ctrl_i == 5'd14) ||
               (ctrl_i == 5'd16);
    a_neg    = a_signed && in1_i[XLEN-1];
    b_neg    = b_signed && in2_i[XLEN-1];
    a_mag    = a_neg ? -in1_i : in1_i;
    b_mag    = b_neg ? -in2_i : in2_i;
    neg_nxt  = 1'b0;
    case (ctrl_i)
      5'd10, 5'd11, 5'd14: neg_nxt = a_neg ^ b_neg;
      5'd12, 5'd16:        neg_nxt = a_neg;
      default:             neg_nxt = 1'b0;
    endcase
  end

  // hi/lo hold {product} for multiply and {remainder, quotient} for divide.
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    rem_sh = {hi, lo[XLEN-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opb};
    hi_nxt = sum[XLEN:1];
    lo_nxt = {sum[0], lo[XLEN-1:1]};
    if (op[2]) begin
      if (!diff[XLEN+1]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
    prod = {hi_nxt, lo_nxt};
    if (res_neg) prod = -prod;
    quo  = div0 ? '1 : (res_neg ? -lo_nxt : lo_nxt);
    rem  = res_neg ? -hi_nxt : hi_nxt;
    case (op)
      3'd0:             fin_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fin_res = quo;
      default:          fin_res = rem;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (kill_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = is_md ? BUSY : DONE;
        BUSY: if (last) state_nxt = DONE;
        DONE: if (ready_i) state_nxt = accept ? (is_md ? BUSY : DONE) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      op       <= '0;
      res_neg  <= 1'b0;
      div0     <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (is_md) begin
          hi      <= '0;
          lo      <= a_mag;
          opb     <= b_mag;
          op      <= 3'(ctrl_i - 5'd10);
          res_neg <= neg_nxt;
          div0    <= (in2_i == '0);
          cnt     <= '0;
        end else begin
          result_o <= alu_res;
          zero_o   <= (alu_res == '0);
        end
      end else if (state == BUSY && !kill_i) begin
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          result_o <= fin_res;
          zero_o   <= (fin_res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed vector table plus hand sequences for backpressure, kill and reset-while-busy.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, valid_i, ready_o, kill_i, valid_o, ready_i, zero_o;
  logic [31:0] in1, in2, result_o;
  logic [4:0]  ctrl;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .in1_i(in1), .in2_i(in2), .ctrl_i(ctrl), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o)
  );

  typedef struct packed {
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input string name);
    int lat;
    int exp_lat;
    exp_lat = (c >= 5'd10 && c <= 5'd17) ? 33 : 1;
    ctrl = c; in1 = a; in2 = b; valid_i = 1'b1; ready_i = 1'b1;
    #1;
    chk({name, " ready"}, 32'(ready_o), 32'd1);
    step();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      step();
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, result_o, e);
    chk({name, " zero"}, 32'(zero_o), 32'(e == 32'd0));
    step();
    chk({name, " valid drop"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rose;
    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    in1 = '0; in2 = '0; ctrl = '0;

    tbl.push_back('{5'd0,  32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0000}); // ADD -> 0
    tbl.push_back('{5'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001}); // SLT
    tbl.push_back('{5'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000}); // SLTU
    tbl.push_back('{5'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
    tbl.push_back('{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0});
    tbl.push_back('{5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0});
    tbl.push_back('{5'd4,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010}); // shamt 36 -> 4
    tbl.push_back('{5'd5,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000});
    tbl.push_back('{5'd6,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000}); // shamt 33 -> 1
    tbl.push_back('{5'd7,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE});
    tbl.push_back('{5'd20, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000});
    tbl.push_back('{5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001}); // MUL
    tbl.push_back('{5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}); // MULH
    tbl.push_back('{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}); // MULHU
    tbl.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}); // MULHSU
    tbl.push_back('{5'd10, 32'h0000_3039, 32'h0000_03E8, 32'h00BC_5EA8});
    tbl.push_back('{5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD}); // DIV -7/2
    tbl.push_back('{5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF}); // REM
    tbl.push_back('{5'd15, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF}); // DIVU /0
    tbl.push_back('{5'd17, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005}); // REMU /0
    tbl.push_back('{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}); // overflow
    tbl.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    tbl.push_back('{5'd14, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF}); // DIV /0
    tbl.push_back('{5'd16, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9}); // REM /0
    tbl.push_back('{5'd15, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E});
    tbl.push_back('{5'd17, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002});

    repeat (3) step();
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset result_o", result_o, 32'd0);
    chk("reset zero_o", 32'(zero_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle ready_o", 32'(ready_o), 32'd1);

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e, $sformatf("vec%0d op%0d", i, tbl[i].c));

    // Result held under backpressure, then back-to-back accept.
    ctrl = 5'd0; in1 = 32'd3; in2 = 32'd4; valid_i = 1'b1; ready_i = 1'b0;
    step();
    in1 = 32'd10; in2 = 32'd20;
    chk("bp first valid", 32'(valid_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp hold result %0d", k), result_o, 32'd7);
      chk($sformatf("bp hold ready_o %0d", k), 32'(ready_o), 32'd0);
      step();
    end
    chk("bp still valid", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    #1;
    chk("bp ready_o follows ready_i", 32'(ready_o), 32'd1);
    step();
    valid_i = 1'b0;
    chk("b2b valid", 32'(valid_o), 32'd1);
    chk("b2b result", result_o, 32'd30);
    step();
    chk("b2b single result", 32'(valid_o), 32'd0);

    // Kill at busy cycle 10: no accept while killing, nothing ever completes.
    ctrl = 5'd14; in1 = 32'd100; in2 = 32'd3; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (9) step();
    kill_i = 1'b1; valid_i = 1'b1; ctrl = 5'd0; in1 = 32'd1; in2 = 32'd1;
    #1;
    chk("kill ready_o", 32'(ready_o), 32'd0);
    step();
    kill_i = 1'b0; valid_i = 1'b0;
    chk("kill valid_o", 32'(valid_o), 32'd0);
    chk("kill result kept", result_o, 32'd30);
    rose = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) rose++;
    end
    chk("kill no result", 32'(rose), 32'd0);

    // Reset at busy cycle 5.
    ctrl = 5'd10; in1 = 32'd9; in2 = 32'd9; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst busy valid_o", 32'(valid_o), 32'd0);
    chk("rst busy result_o", result_o, 32'd0);
    rose = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) rose++;
    end
    chk("rst busy no result", 32'(rose), 32'd0);

    run_op(5'd10, 32'd7, 32'd6, 32'd42, "after abort MUL");
    run_op(5'd14, 32'd100, 32'd3, 32'd33, "after abort DIV");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
